// File: rtl/nor3_seq_pkg.sv
// Shared types and helpers for the 3-input NOR stimulus sequencer.
// Vector ordering and expected-output rules live here so all users agree.
package nor3_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int NUM_VEC = 8;

    function automatic logic [2:0] vec_of(input logic [2:0] idx,
                                          input logic       gray);
        return gray ? (idx ^ (idx >> 1)) : idx;
    endfunction

    function automatic logic nor3_exp(input logic [2:0] vec);
        return ~|vec;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Sticks at all-ones once reached.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] q_q;
    logic [CNT_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr)
            q_d = '0;
        else if (inc && (q_q != '1))
            q_d = q_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            q_q <= '0;
        else
            q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/nor3_stim_seq.sv
// Walks a NOR3 cell through all 8 input vectors, checks QN and
// counts QN activity for power correlation.
module nor3_stim_seq
    import nor3_seq_pkg::*;
#(
    parameter int HOLD_W = 8,
    parameter int LOOP_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [HOLD_W-1:0] HOLD,
    input  logic [LOOP_W-1:0] LOOPS,
    input  logic              GRAY,
    output logic              IN1,
    output logic              IN2,
    output logic              IN3,
    input  logic              QN_S,
    output logic              BUSY,
    output logic              DONE,
    output logic [CNT_W-1:0]  ERR_CNT,
    output logic [CNT_W-1:0]  TGL_CNT
);

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] h_q, h_d;
    logic [LOOP_W-1:0] l_q, l_d;
    logic              gray_q, gray_d;
    logic [2:0]        idx_q, idx_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [LOOP_W-1:0] loop_q, loop_d;
    logic              qnp_q, qnp_d;
    logic [2:0]        vec_q, vec_d;

    logic start_ok;
    logic last_hold;
    logic last_idx;
    logic last_vec;
    logic err_inc;
    logic tgl_inc;

    assign start_ok  = (state_q == IDLE) && START;
    assign last_hold = (hold_q == h_q - 1'b1);
    assign last_idx  = (idx_q == 3'(NUM_VEC - 1));
    assign last_vec  = last_idx && (loop_q == l_q - 1'b1);

    always_ff @(posedge CLK) begin
        if (RST)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (START) state_d = RUN;
            RUN:     if (last_hold && last_vec) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        BUSY = (state_q == RUN);
        DONE = (state_q == FINISH);
    end

    always_comb begin
        h_d    = h_q;
        l_d    = l_q;
        gray_d = gray_q;
        idx_d  = idx_q;
        hold_d = hold_q;
        loop_d = loop_q;
        qnp_d  = qnp_q;
        if (start_ok) begin
            h_d    = (HOLD == '0) ? HOLD_W'(1) : HOLD;
            l_d    = (LOOPS == '0) ? LOOP_W'(1) : LOOPS;
            gray_d = GRAY;
            idx_d  = '0;
            hold_d = '0;
            loop_d = '0;
            qnp_d  = QN_S;
        end else if (state_q == RUN) begin
            qnp_d = QN_S;
            if (last_hold) begin
                hold_d = '0;
                idx_d  = idx_q + 1'b1;
                if (last_idx)
                    loop_d = loop_q + 1'b1;
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    // Drive is registered from next-state so the vector appears with BUSY.
    always_comb begin
        vec_d = 3'b000;
        if (state_d == RUN)
            vec_d = vec_of(idx_d, gray_d);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            h_q    <= '0;
            l_q    <= '0;
            gray_q <= 1'b0;
            idx_q  <= '0;
            hold_q <= '0;
            loop_q <= '0;
            qnp_q  <= 1'b0;
            vec_q  <= '0;
        end else begin
            h_q    <= h_d;
            l_q    <= l_d;
            gray_q <= gray_d;
            idx_q  <= idx_d;
            hold_q <= hold_d;
            loop_q <= loop_d;
            qnp_q  <= qnp_d;
            vec_q  <= vec_d;
        end
    end

    assign IN1 = vec_q[0];
    assign IN2 = vec_q[1];
    assign IN3 = vec_q[2];

    assign err_inc = (state_q == RUN) && last_hold &&
                     (QN_S != nor3_exp(vec_q));
    assign tgl_inc = (state_q == RUN) && (QN_S != qnp_q);

    sat_counter #(.CNT_W(CNT_W)) u_err (
        .clk (CLK),
        .rst (RST),
        .clr (start_ok),
        .inc (err_inc),
        .q   (ERR_CNT)
    );

    sat_counter #(.CNT_W(CNT_W)) u_tgl (
        .clk (CLK),
        .rst (RST),
        .clr (start_ok),
        .inc (tgl_inc),
        .q   (TGL_CNT)
    );

endmodule

// File: tb/tb_nor3_stim_seq.sv
// Scoreboard bench for nor3_stim_seq: 16-bit and 4-bit counter
// instances share stimulus and a sequence-level reference model.
module tb_nor3_stim_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] hold;
    logic [7:0] loops;
    logic       gray;
    logic       flip;
    logic       stuck_en;
    logic       stuck_val;
    logic       qn_s;

    logic        in1, in2, in3, busy, done;
    logic [15:0] err, tgl;
    logic        b_in1, b_in2, b_in3, b_busy, b_done;
    logic [3:0]  b_err, b_tgl;

    typedef struct {
        int err;
        int tgl;
        int ncyc;
    } res_t;

    logic [2:0] exp_vec_q[$];
    res_t       exp_res_q[$];

    int checks = 0;
    int passes = 0;
    int busy_run = 0;

    always #5 clk = ~clk;

    assign qn_s = stuck_en ? stuck_val : (~(in1 | in2 | in3) ^ flip);

    nor3_stim_seq #(.HOLD_W(8), .LOOP_W(8), .CNT_W(16)) dut (
        .CLK(clk), .RST(rst), .START(start), .HOLD(hold),
        .LOOPS(loops), .GRAY(gray), .IN1(in1), .IN2(in2), .IN3(in3),
        .QN_S(qn_s), .BUSY(busy), .DONE(done),
        .ERR_CNT(err), .TGL_CNT(tgl)
    );

    nor3_stim_seq #(.HOLD_W(8), .LOOP_W(8), .CNT_W(4)) dut4 (
        .CLK(clk), .RST(rst), .START(start), .HOLD(hold),
        .LOOPS(loops), .GRAY(gray), .IN1(b_in1), .IN2(b_in2), .IN3(b_in3),
        .QN_S(qn_s), .BUSY(b_busy), .DONE(b_done),
        .ERR_CNT(b_err), .TGL_CNT(b_tgl)
    );

    task automatic chk(input string name, input longint act,
                       input longint exp);
        checks++;
        if (act == exp)
            passes++;
        else
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Monitor: pops one expected vector per BUSY cycle, one result per DONE
    always @(negedge clk) begin
        logic [2:0] v;
        res_t       r;
        if (busy) begin
            if (exp_vec_q.size() == 0) begin
                chk("unexpected_busy", 1, 0);
            end else begin
                v = exp_vec_q.pop_front();
                chk("vec", {in3, in2, in1}, v);
                chk("vec_c4", {b_in3, b_in2, b_in1}, v);
                chk("busy_c4", b_busy, 1);
            end
            busy_run++;
        end
        if (done) begin
            chk("done_in_zero", {in3, in2, in1}, 0);
            chk("done_c4", b_done, 1);
            if (exp_res_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                r = exp_res_q.pop_front();
                chk("err_cnt", err, r.err);
                chk("tgl_cnt", tgl, r.tgl);
                chk("err_cnt_c4", b_err, sat(r.err, 15));
                chk("tgl_cnt_c4", b_tgl, sat(r.tgl, 15));
                chk("busy_len", busy_run, r.ncyc);
            end
        end
        if (!busy)
            busy_run = 0;
    end

    // mode: 0 = ideal NOR with random QN flips, 1 = stuck 0, 2 = stuck 1
    task automatic run(input int h, input int l, input bit g,
                       input int mode, input int flip_pct,
                       input int mid, input int rst_at);
        int   hh, ll, n, e, t, idx;
        bit   prev;
        bit   f[];
        bit   q[];
        logic [2:0] v[];
        hh = (h == 0) ? 1 : h;
        ll = (l == 0) ? 1 : l;
        n  = 8 * ll * hh;
        f  = new[n];
        q  = new[n];
        v  = new[n];
        for (int k = 0; k < n; k++) begin
            idx  = (k / hh) % 8;
            v[k] = g ? 3'(idx ^ (idx >> 1)) : 3'(idx);
            f[k] = (mode == 0) && ($urandom_range(0, 99) < flip_pct);
            case (mode)
                1:       q[k] = 1'b0;
                2:       q[k] = 1'b1;
                default: q[k] = (v[k] == 3'd0) ^ f[k];
            endcase
        end
        prev = (mode == 1) ? 1'b0 : 1'b1;
        e = 0;
        t = 0;
        for (int k = 0; k < n; k++) begin
            if ((k % hh == hh - 1) && (q[k] != (v[k] == 3'd0)))
                e++;
            if (q[k] != prev)
                t++;
            prev = q[k];
        end
        for (int k = 0; k < n; k++)
            if (rst_at < 0 || k <= rst_at)
                exp_vec_q.push_back(v[k]);
        if (rst_at < 0)
            exp_res_q.push_back('{err: e, tgl: t, ncyc: n});

        @(posedge clk); #1;
        hold      = 8'(h);
        loops     = 8'(l);
        gray      = g;
        stuck_en  = (mode != 0);
        stuck_val = (mode == 2);
        flip      = 1'b0;
        start     = 1'b1;
        @(posedge clk); #1;
        hold  = 8'($urandom);
        loops = 8'($urandom);
        gray  = 1'($urandom);
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            flip  = f[k];
            start = (k == mid);
            if (k == rst_at) begin
                rst = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        flip  = 1'b0;
        if (rst_at >= 0) begin
            rst = 1'b0;
            exp_vec_q.delete();
            @(negedge clk);
            chk("rst_in", {in3, in2, in1}, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_err", err, 0);
            chk("rst_tgl", tgl, 0);
            repeat (3) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b1;
        hold      = 8'd1;
        loops     = 8'd1;
        gray      = 1'b0;
        flip      = 1'b0;
        stuck_en  = 1'b0;
        stuck_val = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk("reset_in", {in3, in2, in1}, 0);
            chk("reset_busy", busy, 0);
            chk("reset_done", done, 0);
            chk("reset_err", err, 0);
            chk("reset_tgl", tgl, 0);
        end
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        run(1, 1, 1'b0, 0, 0, -1, -1);
        run(3, 2, 1'b1, 0, 0, -1, -1);
        run(2, 1, 1'b0, 1, 0, 5, -1);
        run(0, 3, 1'b0, 2, 0, -1, -1);
        run(2, 1, 1'b1, 0, 0, -1, 8);
        run(1, 1, 1'b0, 0, 0, -1, -1);
        for (int i = 0; i < 12; i++) begin
            int h, l, n, m;
            h = $urandom_range(0, 4);
            l = $urandom_range(0, 2);
            n = 8 * ((l == 0) ? 1 : l) * ((h == 0) ? 1 : h);
            m = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n - 2) : -1;
            run(h, l, 1'($urandom), $urandom_range(0, 2), 30, m, -1);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("drain_vec", exp_vec_q.size(), 0);
        chk("drain_res", exp_res_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/nor3_stim_seq.md
# nor3_stim_seq

Stimulus sequencer and checker for a 3-input NOR cell under test in the power/characterization benches. On a start pulse it walks the cell's IN1/IN2/IN3 pins through all eight input vectors in binary or Gray order. Each vector is held for a programmable number of cycles, and the sequence repeats for a programmable number of passes. The block checks the cell's QN against the expected NOR value and counts QN transitions for activity and power correlation.

## Interface
- HOLD_W, 8: width of HOLD (cycles per vector)
- LOOP_W, 8: width of LOOPS (passes over the 8 vectors)
- CNT_W, 16: width of ERR_CNT and TGL_CNT
- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- START  in  1  run request; sampled each edge
- HOLD  in  HOLD_W  cycles each vector is held; 0 treated as 1
- LOOPS  in  LOOP_W  number of 8-vector passes; 0 treated as 1
- GRAY  in  1  0 = binary order, 1 = Gray order
- IN1, IN2, IN3  out  1 each  registered drive to the cell; vector {IN3,IN2,IN1}
- QN_S  in  1  cell output, already in the CLK domain
- BUSY  out  1  run in progress
- DONE  out  1  one-cycle pulse on run completion
- ERR_CNT  out  CNT_W  saturating count of mismatches between QN_S and the expected value
- TGL_CNT  out  CNT_W  saturating count of QN_S transitions during the run

## Operation
- States: IDLE, RUN, FINISH.
- Reset value of every output is 0.
- IDLE:
  - START=1 latches H=max(HOLD,1), L=max(LOOPS,1) and GRAY.
  - Clears ERR_CNT and TGL_CNT, loads qn_prev with QN_S, then goes to RUN with idx=0, hold_cnt=0, loop_cnt=0.
- RUN:
  - Vector = idx (binary) or idx^(idx>>1) (Gray), driven on {IN3,IN2,IN1}.
  - Expected value = ~(IN1|IN2|IN3).
  - Every edge: if QN_S != qn_prev, increment TGL_CNT; then qn_prev <= QN_S.
  - On the last hold cycle (hold_cnt==H-1): compare QN_S with the expected value and increment ERR_CNT on mismatch.
  - On that same cycle, advance idx mod 8. When idx wraps, increment loop_cnt.
  - After the last hold cycle of idx 7 in pass L, go to FINISH.
- FINISH: lasts one cycle. DONE=1, BUSY=0, IN*=0, then return to IDLE.
- Counters saturate at all-ones. Their values hold after DONE until the next accepted START.
- START while BUSY or in FINISH is ignored. HOLD, LOOPS and GRAY changes during a run are ignored.
- RST mid-run: at the next edge the block returns to IDLE, all outputs go to 0, and no DONE is produced.

## Timing
- START sampled at edge t: from t+ BUSY=1 and vector 0 is on IN*.
- Each vector occupies exactly H cycles. BUSY stays high for 8·L·H cycles.
- DONE is high for the single cycle right after the last RUN cycle. IN* return to 0 in that same cycle.
- QN_S is sampled at the edge ending a cycle, which gives the cell a full cycle to settle after IN* change.
- Back-to-back runs: START may be asserted in the cycle after DONE.

## Structure
- Shared package nor3_seq_pkg holds:
  - the state enum {IDLE, RUN, FINISH}
  - the constant NUM_VEC=8
  - function vec_of(idx, gray) returning the 3-bit vector
  - function nor3_exp(vec)
- One sub-module, sat_counter (param CNT_W; ports clr, inc, q), instantiated for ERR_CNT and for TGL_CNT.

## Test plan
- Reset: hold RST 2 cycles with START=1 → IN*, BUSY, DONE, ERR_CNT and TGL_CNT all 0; no run starts.
- HOLD=1, LOOPS=1, GRAY=0, QN_S from an ideal NOR model → IN sequence 0..7 one per cycle; BUSY 8 cycles; DONE the next cycle; ERR_CNT=0, TGL_CNT=1.
- HOLD=3, LOOPS=2, GRAY=1, ideal model → order 0,1,3,2,6,7,5,4, each vector 3 cycles; BUSY 48 cycles; ERR_CNT=0, TGL_CNT=3.
- QN_S stuck at 0, HOLD=2, LOOPS=1 → ERR_CNT=1 (vector 0 only), TGL_CNT=0; START pulse mid-run has no effect on sequence or length.
- Configuration CNT_W=4, QN_S stuck at 1, HOLD=0, LOOPS=3 → each vector lasts 1 cycle; BUSY 24 cycles; ERR_CNT saturates at 15 (21 raw), TGL_CNT=0.
- RST asserted during vector 4 of a run → next cycle IN*=0, BUSY=0, counters 0, no DONE; a fresh START afterwards completes normally.
